// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - width helpers and signed saturation shared by the conv MAC datapath
package conv_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Unsigned pixels gain a zero sign bit before the multiply, hence the extra product bit.
  function automatic int pw_of(input int dw, input int data_signed);
    return 2 * dw + ((data_signed != 0) ? 0 : 1);
  endfunction

  function automatic int sw_of(input int dw, input int data_signed, input int lanes);
    return pw_of(dw, data_signed) + clog2(lanes);
  endfunction

  function automatic int acc_w_of(input int dw, input int data_signed, input int lanes,
                                  input int rows);
    return pw_of(dw, data_signed) + clog2(lanes * rows);
  endfunction

  // Clamp a signed in_w-bit value (carried sign-extended in 64 bits) to the signed out_w range.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int in_w, input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (out_w >= in_w) return v;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mac_lane_sum.sv
// rtl/mac_lane_sum.sv - per-lane extend and multiply, summed into one signed beat total
module mac_lane_sum
  import conv_pkg::*;
#(
  parameter int LANES       = 3,
  parameter int DW          = 8,
  parameter int DATA_SIGNED = 1,
  parameter int SW          = sw_of(DW, DATA_SIGNED, LANES)
) (
  input  logic [LANES*DW-1:0] data,
  input  logic [LANES*DW-1:0] weight,
  output logic signed [SW-1:0] sum
);

  // Every operand is extended to SW bits first, so the true sum always fits.
  always_comb begin
    logic signed [SW-1:0] d_ext;
    logic signed [SW-1:0] w_ext;
    logic signed [SW-1:0] total;
    d_ext = '0;
    w_ext = '0;
    total = '0;
    for (int i = 0; i < LANES; i++) begin
      if (DATA_SIGNED != 0) d_ext = SW'($signed(data[i*DW +: DW]));
      else                  d_ext = SW'(data[i*DW +: DW]);
      w_ext = SW'($signed(weight[i*DW +: DW]));
      total = total + d_ext * w_ext;
    end
    sum = total;
  end

endmodule

// File: rtl/conv_mac_pipe.sv
// rtl/conv_mac_pipe.sv - two-stage windowed MAC with handshakes, flush and output saturation
module conv_mac_pipe
  import conv_pkg::*;
#(
  parameter int LANES       = 3,
  parameter int DW          = 8,
  parameter int ROWS        = 3,
  parameter int DATA_SIGNED = 1,
  parameter int OUT_W       = 20,
  parameter int SATURATE    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] data,
  input  logic [LANES*DW-1:0] weight,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    result
);

  localparam int SW    = sw_of(DW, DATA_SIGNED, LANES);
  localparam int ACC_W = acc_w_of(DW, DATA_SIGNED, LANES, ROWS);
  localparam int CW    = (ROWS > 1) ? clog2(ROWS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ROWS - 1);

  logic                    en;
  logic                    accept;
  logic [CW-1:0]           cnt;
  logic signed [SW-1:0]    lane_sum;
  logic signed [SW-1:0]    s1_sum;
  logic                    s1_first;
  logic                    s1_last;
  logic                    s1_valid;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic [OUT_W-1:0]        fit_val;

  assign en       = !out_valid || out_ready;
  assign in_ready = en && !flush;
  assign accept   = in_valid && in_ready;

  mac_lane_sum #(
    .LANES      (LANES),
    .DW         (DW),
    .DATA_SIGNED(DATA_SIGNED),
    .SW         (SW)
  ) u_lane_sum (
    .data  (data),
    .weight(weight),
    .sum   (lane_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else if (flush) begin
      cnt      <= '0;
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_sum   <= lane_sum;
      s1_first <= (cnt == '0);
      s1_last  <= (cnt == CNT_LAST);
      s1_valid <= 1'b1;
      cnt      <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end else if (en) begin
      s1_valid <= 1'b0;
    end
  end

  // The first beat of a window reloads the accumulator, so windows chain with no bubble.
  always_comb begin
    acc_next = s1_first ? ACC_W'(s1_sum) : acc + ACC_W'(s1_sum);
    if (SATURATE != 0) fit_val = OUT_W'(sat_signed(64'(acc_next), ACC_W, OUT_W));
    else               fit_val = OUT_W'(acc_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (en && s1_valid) begin
        acc <= acc_next;
        if (s1_last) result <= fit_val;
      end
      if (en && s1_valid && s1_last) out_valid <= 1'b1;
      else if (out_ready)            out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/conv_mac_pipe.md
Name: conv_mac_pipe

Overview:
Parametrised multiply-accumulate engine for the 2D convolution datapath. Each accepted beat multiplies LANES data/weight pairs and sums them. ROWS consecutive beats form one kernel window, and the block emits one accumulated window result. It is the generalised successor of the fixed 3x3 MAC:
- configurable lanes, width and window depth
- valid/ready handshakes on input and output
- selectable signed or unsigned pixel data
- output saturation
- flush of a partial window

Parameters:
LANES, 3, multiply lanes per beat (kernel width)
DW, 8, bit width of each data and weight element
ROWS, 3, beats per window (kernel height), >=1
DATA_SIGNED, 1, 1 = data elements are two's complement; 0 = data elements are unsigned pixels (weights are always signed)
OUT_W, 20, result width; must be <= ACC_W
SATURATE, 1, 1 = clamp to the signed OUT_W range; 0 = keep the low OUT_W bits

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort of the partial window
in_valid  in  1  beat offered
in_ready  out  1  beat can be accepted
data  in  LANES*DW  lane i occupies bits [i*DW +: DW]
weight  in  LANES*DW  signed, same packing as data
out_valid  out  1  result held
out_ready  in  1  downstream accepts the result
result  out  OUT_W  signed window sum

Behaviour:
- Reset is asynchronous on the falling edge of rst_n. It clears out_valid, result, the beat counter, the stage-1 valid and the accumulator, all to 0. Reset mid-window discards the window.
- Widths:
  - PW = 2*DW + (DATA_SIGNED ? 0 : 1); unsigned data is zero-extended by 1 bit before the multiply.
  - SW = PW + clog2(LANES).
  - ACC_W = PW + clog2(LANES*ROWS).
  - All sums are sign-extended, so there is no internal overflow.
- Pipeline enable: en = !out_valid || out_ready.
- in_ready = en && !flush. A beat is accepted when in_valid && in_ready.
- Stage 1, on an accepted beat:
  - Register the lane-product sum s1_sum.
  - Register s1_first = (cnt == 0) and s1_last = (cnt == ROWS-1).
  - Set s1_valid = 1.
  - Advance cnt; it wraps from ROWS-1 to 0.
  - With ROWS == 1, first and last are asserted together.
- Stage 2, when en && s1_valid:
  - acc_next = s1_first ? s1_sum : acc + s1_sum; acc <= acc_next.
  - If s1_last: result <= fit(acc_next) and out_valid <= 1.
  - When en is high and no beat is accepted, s1_valid <= 0. When en is low, stage 1 holds.
- fit():
  - SATURATE = 1: values above 2^(OUT_W-1)-1 clamp to that value; values below -2^(OUT_W-1) clamp to that value.
  - SATURATE = 0: truncate to the low OUT_W bits.
  - When OUT_W == ACC_W, fit() is the identity.
- Output register:
  - out_valid clears on out_valid && out_ready unless a new last beat writes in the same cycle. In that case result is replaced and out_valid stays 1.
  - result is stable while out_valid && !out_ready.
- Latency: the last beat accepted at edge t gives out_valid = 1 after edge t+1 (2 cycles).
- Throughput: back-to-back windows run at 1 beat/clk with no bubble; the first beat reloads acc.
- Flush (high at an edge):
  - cnt <= 0 and s1_valid <= 0; no beat is accepted that cycle.
  - out_valid and result are untouched, and the output handshake proceeds normally.
- Flush with in_valid in the same cycle: flush wins and the beat is not accepted.

Decomposition:
- Shared package conv_pkg holds:
  - width helpers: a clog2 function and the PW/SW/ACC_W derivation
  - a signed saturate function parameterised by the input and output widths
- Sub-module mac_lane_sum holds the combinational part: per-lane extend and multiply, plus the adder tree, producing SW bits.
- conv_mac_pipe holds the counter, both pipeline stages, the accumulator, saturation and the handshakes.

Test Plan:
- Defaults, window-sum check: three beats with data lanes {1,2,3} and weights {1,1,1}, out_ready = 1 -> one result = 18, out_valid for 1 cycle, 2 cycles after the last beat.
- Signed extremes, full width: all lanes data = -128, weight = -128, 3 beats -> result = 147456 with no overflow.
- Saturation, OUT_W = 16, SATURATE = 1:
  - inputs from the previous scenario -> 32767
  - data = -128, weight = 127 -> -32768
- Saturation, OUT_W = 16, SATURATE = 0: data = -128, weight = -128 -> 16384 (147456 truncated).
- Unsigned data, DATA_SIGNED = 0: data = 255 (0xFF), weight = -1 on all lanes for 3 beats -> result = -2295.
- Backpressure: two windows streamed back to back with out_ready held low -> first result held stable and in_ready drops. On releasing out_ready, both results emerge in order with no beat lost or duplicated.
- Flush and reset mid-window: flush after beat 2, then 3 new beats of sum 5 -> result = 15. Separately, pull rst_n low mid-window -> all outputs 0 immediately, and the next full window is computed correctly.
